// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: CALL/RET sequencer state encoding and stack constants.
// STACK_OFFSET must stay in step with the stack base used by cpu_registers.
package chip8_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_HI,
    ST_INC1,
    ST_PUSH_LO,
    ST_INC2,
    ST_DEC1,
    ST_POP_LO,
    ST_DEC2,
    ST_POP_HI,
    ST_LOAD
  } stack_state_e;

  localparam int          RET_OFFSET   = 2;
  localparam logic [15:0] STACK_OFFSET = 16'd240;
  localparam int          DEPTH_W      = 5;

  function automatic logic [15:0] calc_return_addr(input logic [15:0] pc,
                                                   input logic [15:0] offset);
    return pc + offset;
  endfunction

endpackage

// File: rtl/cpu_stack_ctrl.sv
// CALL/RET sequencer: pushes/pops the 16-bit return address as two bytes through
// a req/ack byte port and drives the sp/pc strobes of cpu_registers.
module cpu_stack_ctrl #(
  parameter int STACK_DEPTH = 16,
  parameter int RET_OFFSET  = chip8_pkg::RET_OFFSET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic [11:0] call_target,
  input  logic [15:0] pc_cur,
  input  logic [15:0] sp_addr,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic [15:0] pc_in,
  output logic        pc_inc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [4:0]  depth
);

  import chip8_pkg::*;

  localparam logic [4:0] DEPTH_FULL = 5'(STACK_DEPTH);

  stack_state_e state_q, state_d;
  logic [4:0]   depth_q, depth_d;
  logic [15:0]  ret_addr_q, ret_addr_d;
  logic [11:0]  target_q, target_d;
  logic [7:0]   pop_lo_q, pop_lo_d;
  logic [15:0]  pc_in_q, pc_in_d;
  logic         sp_inc_q, sp_inc_d;
  logic         sp_dec_q, sp_dec_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [7:0]   mem_wdata_q, mem_wdata_d;
  logic         pc_inc_q, pc_inc_d;
  logic         done_q, done_d;
  logic         fault_q, fault_d;

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    ret_addr_d = ret_addr_q;
    target_d   = target_q;
    pop_lo_d   = pop_lo_q;
    pc_in_d    = pc_in_q;
    fault_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (call_req) begin
          if (depth_q == DEPTH_FULL) begin
            fault_d = 1'b1;
          end else begin
            ret_addr_d = calc_return_addr(pc_cur, 16'(RET_OFFSET));
            target_d   = call_target;
            state_d    = ST_PUSH_HI;
          end
        end else if (ret_req) begin
          if (depth_q == 5'd0) begin
            fault_d = 1'b1;
          end else begin
            state_d = ST_DEC1;
          end
        end
      end
      ST_PUSH_HI: if (mem_ack) state_d = ST_INC1;
      ST_INC1:    state_d = ST_PUSH_LO;
      ST_PUSH_LO: if (mem_ack) state_d = ST_INC2;
      ST_INC2: begin
        depth_d = depth_q + 5'd1;
        pc_in_d = {4'h0, target_q};
        state_d = ST_LOAD;
      end
      ST_DEC1: begin
        depth_d = depth_q - 5'd1;
        state_d = ST_POP_LO;
      end
      ST_POP_LO: begin
        if (mem_ack) begin
          pop_lo_d = mem_rdata;
          state_d  = ST_DEC2;
        end
      end
      ST_DEC2:    state_d = ST_POP_HI;
      ST_POP_HI: begin
        if (mem_ack) begin
          pc_in_d = {mem_rdata, pop_lo_q};
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight off a flop.
  always_comb begin
    sp_inc_d    = (state_d == ST_INC1) || (state_d == ST_INC2);
    sp_dec_d    = (state_d == ST_DEC1) || (state_d == ST_DEC2);
    mem_req_d   = (state_d == ST_PUSH_HI) || (state_d == ST_PUSH_LO) ||
                  (state_d == ST_POP_LO)  || (state_d == ST_POP_HI);
    mem_we_d    = (state_d == ST_PUSH_HI) || (state_d == ST_PUSH_LO);
    mem_wdata_d = 8'h00;
    if (state_d == ST_PUSH_HI) begin
      mem_wdata_d = ret_addr_d[15:8];
    end else if (state_d == ST_PUSH_LO) begin
      mem_wdata_d = ret_addr_d[7:0];
    end
    pc_inc_d    = (state_d == ST_LOAD);
    done_d      = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      depth_q     <= 5'd0;
      ret_addr_q  <= 16'h0000;
      target_q    <= 12'h000;
      pop_lo_q    <= 8'h00;
      pc_in_q     <= 16'h0000;
      sp_inc_q    <= 1'b0;
      sp_dec_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      pc_inc_q    <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      ret_addr_q  <= ret_addr_d;
      target_q    <= target_d;
      pop_lo_q    <= pop_lo_d;
      pc_in_q     <= pc_in_d;
      sp_inc_q    <= sp_inc_d;
      sp_dec_q    <= sp_dec_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      pc_inc_q    <= pc_inc_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  // sp only moves on our own strobes, so it is already stable for the whole access.
  assign mem_addr  = sp_addr;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign sp_inc    = sp_inc_q;
  assign sp_dec    = sp_dec_q;
  assign pc_in     = pc_in_q;
  assign pc_inc    = pc_inc_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign depth     = depth_q;
  assign busy      = (state_q != ST_IDLE);

  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(mem_req_q && (sp_inc_q || sp_dec_q)));

  a_depth_range: assert property (@(posedge clk) disable iff (rst)
    depth_q <= DEPTH_FULL);

endmodule
